// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM states,
// message layouts and ALU function codes.
package alu_req_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned FN_W       = 4;
    localparam int unsigned FLAG_W     = 3;
    localparam int unsigned REQ_MSG_W  = FN_W + 2 * DATA_W;
    localparam int unsigned RESP_MSG_W = FLAG_W + DATA_W;

    // Request layout: [67:64] fn, [63:32] in0, [31:0] in1
    localparam int unsigned REQ_FN_LSB  = 2 * DATA_W;
    localparam int unsigned REQ_IN0_LSB = DATA_W;
    localparam int unsigned REQ_IN1_LSB = 0;

    // Response layout: [34] ltu, [33] lt, [32] eq, [31:0] result
    localparam int unsigned RESP_LTU_BIT = DATA_W + 2;
    localparam int unsigned RESP_LT_BIT  = DATA_W + 1;
    localparam int unsigned RESP_EQ_BIT  = DATA_W;

    typedef struct packed {
        logic [FN_W-1:0]   fn;
        logic [DATA_W-1:0] in0;
        logic [DATA_W-1:0] in1;
    } req_msg_t;

    typedef struct packed {
        logic              ltu;
        logic              lt;
        logic              eq;
        logic [DATA_W-1:0] result;
    } resp_msg_t;

    localparam logic [FN_W-1:0] ALU_FN_ADD    = 4'd0;
    localparam logic [FN_W-1:0] ALU_FN_SUB    = 4'd1;
    localparam logic [FN_W-1:0] ALU_FN_AND    = 4'd2;
    localparam logic [FN_W-1:0] ALU_FN_OR     = 4'd3;
    localparam logic [FN_W-1:0] ALU_FN_XOR    = 4'd4;
    localparam logic [FN_W-1:0] ALU_FN_SLT    = 4'd5;
    localparam logic [FN_W-1:0] ALU_FN_SLTU   = 4'd6;
    localparam logic [FN_W-1:0] ALU_FN_SRA    = 4'd7;
    localparam logic [FN_W-1:0] ALU_FN_SRL    = 4'd8;
    localparam logic [FN_W-1:0] ALU_FN_SLL    = 4'd9;
    localparam logic [FN_W-1:0] ALU_FN_RSVD10 = 4'd10;
    localparam logic [FN_W-1:0] ALU_FN_CP_OP0 = 4'd11;
    localparam logic [FN_W-1:0] ALU_FN_CP_OP1 = 4'd12;

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-input round-robin grant: a single pointer picks the winner on a tie
// and moves to the loser whenever a grant is taken.
module alu_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic       grant_id
);

    logic ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (take) begin
            ptr <= ~grant_id;
        end
    end

    // A lone requester wins outright; ties and silence fall to the pointer.
    always_comb begin
        grant_id = ptr;
        if (req == 2'b01) begin
            grant_id = 1'b0;
        end else if (req == 2'b10) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Serialises operations from two requesters through one shared ALU,
// one operation at a time (IDLE -> CALC -> RESP).
module alu_req_arbiter
    import alu_req_arbiter_pkg::*;
#(
    parameter int unsigned p_nbits = 32
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          req0_val,
    output logic                          req0_rdy,
    input  logic [2*p_nbits+FN_W-1:0]     req0_msg,

    input  logic                          req1_val,
    output logic                          req1_rdy,
    input  logic [2*p_nbits+FN_W-1:0]     req1_msg,

    output logic                          resp0_val,
    input  logic                          resp0_rdy,
    output logic [p_nbits+FLAG_W-1:0]     resp0_msg,

    output logic                          resp1_val,
    input  logic                          resp1_rdy,
    output logic [p_nbits+FLAG_W-1:0]     resp1_msg,

    output logic [FN_W-1:0]               alu_fn,
    output logic [p_nbits-1:0]            alu_in0,
    output logic [p_nbits-1:0]            alu_in1,
    input  logic [p_nbits-1:0]            alu_out,
    input  logic                          alu_ops_eq,
    input  logic                          alu_ops_lt,
    input  logic                          alu_ops_ltu
);

    localparam int unsigned REQ_W  = 2 * p_nbits + FN_W;
    localparam int unsigned RESP_W = p_nbits + FLAG_W;

    state_t               state;
    state_t               state_next;
    logic                 grant_id;
    logic                 accept;
    logic [REQ_W-1:0]     msg_sel;
    logic                 owner;
    logic [FN_W-1:0]      fn_q;
    logic [p_nbits-1:0]   in0_q;
    logic [p_nbits-1:0]   in1_q;
    logic [RESP_W-1:0]    resp_q;

    alu_rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      ({req1_val, req0_val}),
        .take     (accept),
        .grant_id (grant_id)
    );

    always_comb begin
        msg_sel = grant_id ? req1_msg : req0_msg;
        accept  = (state == IDLE) && (grant_id ? req1_val : req0_val);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture on accept, ALU result capture at the end of CALC.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner  <= 1'b0;
            fn_q   <= '0;
            in0_q  <= '0;
            in1_q  <= '0;
            resp_q <= '0;
        end else begin
            if (accept) begin
                owner <= grant_id;
                fn_q  <= msg_sel[REQ_W-1 -: FN_W];
                in0_q <= msg_sel[2*p_nbits-1 -: p_nbits];
                in1_q <= msg_sel[p_nbits-1:0];
            end
            if (state == CALC) begin
                resp_q <= {alu_ops_ltu, alu_ops_lt, alu_ops_eq, alu_out};
            end
        end
    end

    // Everything is held quiet while reset is asserted, whatever the state.
    always_comb begin
        state_next = state;
        req0_rdy   = 1'b0;
        req1_rdy   = 1'b0;
        resp0_val  = 1'b0;
        resp1_val  = 1'b0;
        resp0_msg  = '0;
        resp1_msg  = '0;
        alu_fn     = '0;
        alu_in0    = '0;
        alu_in1    = '0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    req0_rdy = ~grant_id;
                    req1_rdy = grant_id;
                    if (accept) begin
                        state_next = CALC;
                    end
                end
                CALC: begin
                    alu_fn     = fn_q;
                    alu_in0    = in0_q;
                    alu_in1    = in1_q;
                    state_next = RESP;
                end
                RESP: begin
                    if (owner) begin
                        resp1_val = 1'b1;
                        resp1_msg = resp_q;
                        if (resp1_rdy) begin
                            state_next = IDLE;
                        end
                    end else begin
                        resp0_val = 1'b1;
                        resp0_msg = resp_q;
                        if (resp0_rdy) begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: fixed vectors, directed corner
// sequences and randomized traffic against a transaction-level model.
module tb_alu_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_val, req0_rdy, req1_val, req1_rdy;
    logic [67:0] req0_msg, req1_msg;
    logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [34:0] resp0_msg, resp1_msg;
    logic [3:0]  alu_fn;
    logic [31:0] alu_in0, alu_in1, alu_out;
    logic        alu_ops_eq, alu_ops_lt, alu_ops_ltu;

    int total = 0;
    int bad   = 0;

    alu_req_arbiter #(.p_nbits(32)) dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
        .alu_fn(alu_fn), .alu_in0(alu_in0), .alu_in1(alu_in1),
        .alu_out(alu_out), .alu_ops_eq(alu_ops_eq),
        .alu_ops_lt(alu_ops_lt), .alu_ops_ltu(alu_ops_ltu)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
        case (fn)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return {31'd0, $signed(a) < $signed(b)};
            4'd6:  return {31'd0, a < b};
            4'd7:  return $unsigned($signed(a) >>> b[4:0]);
            4'd8:  return a >> b[4:0];
            4'd9:  return a << b[4:0];
            4'd11: return a;
            4'd12: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [34:0] ref_resp(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
        return {a < b, $signed(a) < $signed(b), a == b, ref_alu(fn, a, b)};
    endfunction

    // Shared ALU stand-in
    always_comb begin
        alu_out     = ref_alu(alu_fn, alu_in0, alu_in1);
        alu_ops_eq  = (alu_in0 == alu_in1);
        alu_ops_lt  = ($signed(alu_in0) < $signed(alu_in1));
        alu_ops_ltu = (alu_in0 < alu_in1);
    end

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic rsp_val(input int id);
        return (id == 0) ? resp0_val : resp1_val;
    endfunction

    function automatic logic [34:0] rsp_msg(input int id);
        return (id == 0) ? resp0_msg : resp1_msg;
    endfunction

    task automatic idle_inputs();
        req0_val = 1'b0; req1_val = 1'b0;
        req0_msg = '0;   req1_msg = '0;
        resp0_rdy = 1'b0; resp1_rdy = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Returns at the negedge of the cycle in which requester id is accepted.
    task automatic wait_grant(input int id, input string name, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((id == 0 && req0_val && req0_rdy) || (id == 1 && req1_val && req1_rdy)) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_grant"}, 72'(ok), 72'(1));
    endtask

    // One full operation with resp_rdy already high; checks the N+2 latency.
    task automatic run_op(input int id, input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [34:0] exp, input string name);
        bit ok;
        if (id == 0) begin req0_msg = {fn, a, b}; req0_val = 1'b1; end
        else         begin req1_msg = {fn, a, b}; req1_val = 1'b1; end
        wait_grant(id, name, ok);
        if (ok) begin
            @(posedge clk); #1;
            req0_val = 1'b0; req1_val = 1'b0;
            @(negedge clk);
            check({name, "_lat1"}, 72'(rsp_val(id)), 72'(0));
            @(negedge clk);
            check({name, "_lat2"}, 72'(rsp_val(id)), 72'(1));
            check({name, "_msg"}, 72'(rsp_msg(id)), 72'(exp));
            @(posedge clk); #1;
        end
        req0_val = 1'b0; req1_val = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [34:0] exp;
    } vec_t;

    vec_t vecs[9];

    int          phase, turn, owner, g, n;
    logic [3:0]  sfn;
    logic [31:0] sa, sb;
    logic [34:0] sexp, e_m0, e_m1;
    logic [67:0] e_alu;
    logic        e_rdy0, e_rdy1, e_v0, e_v1;
    int          order[6];
    bit          ok;

    initial begin
        // {ltu, lt, eq, result}
        vecs[0] = '{4'd0,  32'd5,          32'd7,          {3'b110, 32'd12}};
        vecs[1] = '{4'd13, 32'd1,          32'd2,          {3'b110, 32'd0}};
        vecs[2] = '{4'd1,  32'd10,         32'd3,          {3'b000, 32'd7}};
        vecs[3] = '{4'd7,  32'h8000_0000,  32'd4,          {3'b010, 32'hF800_0000}};
        vecs[4] = '{4'd2,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  {3'b010, 32'h00F0_00F0}};
        vecs[5] = '{4'd10, 32'd3,          32'd3,          {3'b001, 32'd0}};
        vecs[6] = '{4'd5,  32'hFFFF_FFFF,  32'd1,          {3'b010, 32'd1}};
        vecs[7] = '{4'd6,  32'hFFFF_FFFF,  32'd1,          {3'b010, 32'd0}};
        vecs[8] = '{4'd11, 32'hDEAD_BEEF,  32'h1234_5678,  {3'b010, 32'hDEAD_BEEF}};

        // Reset values, during and after reset
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req1_rdy", 72'(req1_rdy), 72'(0));
        check("rst_resp_val", 72'({resp1_val, resp0_val}), 72'(0));
        check("rst_resp_msg", 72'({resp1_msg, resp0_msg}), 72'(0));
        check("rst_alu", 72'({alu_fn, alu_in0, alu_in1}), 72'(0));
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", 72'({req1_rdy, req0_rdy}), 72'(2'b01));
        check("post_rst_alu", 72'({alu_fn, alu_in0, alu_in1}), 72'(0));

        // Fixed vectors, alternating requesters, resp_rdy held high early
        @(posedge clk); #1;
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            run_op(i % 2, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Contention right after reset: requester 0 first, then 1
        do_reset();
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        req0_msg = {4'd1, 32'd10, 32'd3};         req0_val = 1'b1;
        req1_msg = {4'd7, 32'h8000_0000, 32'd4};  req1_val = 1'b1;
        wait_grant(0, "cont0", ok);
        check("cont0_req1_rdy", 72'(req1_rdy), 72'(0));
        @(posedge clk); #1 req0_val = 1'b0;
        repeat (2) @(negedge clk);
        check("cont0_val", 72'({resp1_val, resp0_val}), 72'(2'b01));
        check("cont0_msg", 72'(resp0_msg), 72'({3'b000, 32'd7}));
        wait_grant(1, "cont1", ok);
        @(posedge clk); #1 req1_val = 1'b0;
        repeat (2) @(negedge clk);
        check("cont1_val", 72'({resp1_val, resp0_val}), 72'(2'b10));
        check("cont1_msg", 72'(resp1_msg), 72'({3'b010, 32'hF800_0000}));

        // Fairness under continuous contention
        do_reset();
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        req0_msg = {4'd0, 32'd1, 32'd1}; req1_msg = {4'd0, 32'd2, 32'd2};
        req0_val = 1'b1; req1_val = 1'b1;
        n = 0;
        for (int k = 0; k < 60 && n < 6; k++) begin
            @(negedge clk);
            if (req0_val && req0_rdy) begin order[n] = 0; n++; end
            else if (req1_val && req1_rdy) begin order[n] = 1; n++; end
        end
        check("fair_count", 72'(n), 72'(6));
        for (int i = 0; i < n; i++) check($sformatf("fair_grant%0d", i), 72'(order[i]), 72'(i % 2));

        // Backpressure on requester 1 with distractions from requester 0
        do_reset();
        req1_msg = {4'd0, 32'd100, 32'd23}; req1_val = 1'b1;
        wait_grant(1, "bp", ok);
        @(posedge clk); #1;
        req1_val = 1'b0;
        req0_msg = {4'd0, 32'd9, 32'd9}; req0_val = 1'b1; resp0_rdy = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_val%0d", k), 72'({resp1_val, resp0_val}), 72'(2'b10));
            check($sformatf("bp_msg%0d", k), 72'(resp1_msg), 72'({3'b000, 32'd123}));
            check($sformatf("bp_rdy%0d", k), 72'({req1_rdy, req0_rdy}), 72'(0));
        end
        @(posedge clk); #1;
        req0_val = 1'b0; resp1_rdy = 1'b1;
        @(negedge clk);
        check("bp_release_val", 72'(resp1_val), 72'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_done_val", 72'(resp1_val), 72'(0));
        check("bp_done_rdy", 72'({req1_rdy, req0_rdy}), 72'(2'b01));

        // Reset in CALC aborts the operation
        do_reset();
        resp0_rdy = 1'b1;
        req0_msg = {4'd0, 32'd1, 32'd1}; req0_val = 1'b1;
        wait_grant(0, "abort", ok);
        @(posedge clk); #1;
        req0_val = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("abort_alu", 72'({alu_fn, alu_in0, alu_in1}), 72'(0));
        @(posedge clk); #1 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("abort_val%0d", k), 72'({resp1_val, resp0_val}), 72'(0));
            check($sformatf("abort_rdy%0d", k), 72'({req1_rdy, req0_rdy}), 72'(2'b01));
        end

        // Randomized traffic against a transaction-level model
        do_reset();
        phase = -1; turn = 0; owner = 0;
        sfn = '0; sa = '0; sb = '0; sexp = '0; g = 0;
        for (int c = 0; c < 400; c++) begin
            req0_val  = 1'($urandom_range(0, 1));
            req1_val  = 1'($urandom_range(0, 1));
            req0_msg  = {4'($urandom_range(0, 15)), 32'($urandom), 32'($urandom)};
            req1_msg  = {4'($urandom_range(0, 15)), 32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 7) == 0) req0_msg[31:0] = req0_msg[63:32];
            if ($urandom_range(0, 7) == 0) req1_msg[31:0] = req1_msg[63:32];
            resp0_rdy = ($urandom_range(0, 3) != 0);
            resp1_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e_rdy0 = 1'b0; e_rdy1 = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0;
            e_m0 = '0; e_m1 = '0; e_alu = '0;
            if (phase < 0) begin
                g = (req0_val && !req1_val) ? 0 : (req1_val && !req0_val) ? 1 : turn;
                e_rdy0 = (g == 0); e_rdy1 = (g == 1);
            end else if (phase == 0) begin
                e_alu = {sfn, sa, sb};
            end else if (owner == 0) begin
                e_v0 = 1'b1; e_m0 = sexp;
            end else begin
                e_v1 = 1'b1; e_m1 = sexp;
            end
            check("rnd_rdy", 72'({req1_rdy, req0_rdy}), 72'({e_rdy1, e_rdy0}));
            check("rnd_val", 72'({resp1_val, resp0_val}), 72'({e_v1, e_v0}));
            check("rnd_msg0", 72'(resp0_msg), 72'(e_m0));
            check("rnd_msg1", 72'(resp1_msg), 72'(e_m1));
            check("rnd_alu", 72'({alu_fn, alu_in0, alu_in1}), 72'(e_alu));
            if (phase < 0) begin
                if ((g == 0 && req0_val) || (g == 1 && req1_val)) begin
                    owner = g;
                    turn  = 1 - g;
                    {sfn, sa, sb} = (g == 1) ? req1_msg : req0_msg;
                    sexp  = ref_resp(sfn, sa, sb);
                    phase = 0;
                end
            end else if (phase == 0) begin
                phase = 1;
            end else if ((owner == 0) ? resp0_rdy : resp1_rdy) begin
                phase = -1;
            end
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
